// File: rtl/dmem_arbiter_if.sv
// Request/response channel between one requester (MEM stage or loader) and the data-memory arbiter.
// The arbiter connects through the slave modport and requesters through the master modport.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 8
) ();

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic [2:0]        req_ltype;
  logic [1:0]        req_stype;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_ltype, req_stype,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_ltype, req_stype,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer for the byte-addressed data memory: one accepted access per
// IDLE cycle, a single ISSUE (or ERR) cycle, then a registered one-cycle response pulse.
module dmem_arbiter #(
  parameter int ADDR_W     = 8,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  dmem_arbiter_if.slave     p0,
  dmem_arbiter_if.slave     p1,
  output logic              mem_rd_en_o,
  output logic              mem_wr_en_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wr_data_o,
  output logic [2:0]        mem_load_type_o,
  output logic [1:0]        mem_store_type_o,
  input  logic [31:0]       mem_rd_data_i
);

  localparam logic [2:0] LOAD_B  = 3'b000;
  localparam logic [2:0] LOAD_H  = 3'b001;
  localparam logic [2:0] LOAD_W  = 3'b010;
  localparam logic [2:0] LOAD_BU = 3'b100;
  localparam logic [2:0] LOAD_HU = 3'b101;
  localparam logic [1:0] STORE_B = 2'b00;
  localparam logic [1:0] STORE_H = 2'b01;
  localparam logic [1:0] STORE_W = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    ERR   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              last_grant_q;
  logic [1:0]        grant;
  logic              accept;
  logic              sel;

  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [31:0]       sel_wdata;
  logic [2:0]        sel_ltype;
  logic [1:0]        sel_stype;
  logic              misalign;

  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [2:0]        ltype_q;
  logic [1:0]        stype_q;
  logic              port_q;

  logic [1:0]        rsp_valid_q;
  logic [31:0]       rsp_rdata_q [2];
  logic [1:0]        rsp_err_q;

  // last_grant names the port that won most recently; on a conflict the other port goes next.
  always_comb begin
    grant = {p1.req_valid, p0.req_valid};
    if (p0.req_valid && p1.req_valid) begin
      if (FIXED_PRIO || last_grant_q) grant = 2'b01;
      else                            grant = 2'b10;
    end
  end

  assign p0.req_ready = (state_q == IDLE) && grant[0];
  assign p1.req_ready = (state_q == IDLE) && grant[1];
  assign accept       = (state_q == IDLE) && (grant != 2'b00);
  assign sel          = grant[1];

  assign sel_we    = sel ? p1.req_we    : p0.req_we;
  assign sel_addr  = sel ? p1.req_addr  : p0.req_addr;
  assign sel_wdata = sel ? p1.req_wdata : p0.req_wdata;
  assign sel_ltype = sel ? p1.req_ltype : p0.req_ltype;
  assign sel_stype = sel ? p1.req_stype : p0.req_stype;

  // Unknown type codes are checked with word alignment.
  always_comb begin
    misalign = 1'b0;
    if (sel_we) begin
      unique case (sel_stype)
        STORE_B: misalign = 1'b0;
        STORE_H: misalign = sel_addr[0];
        STORE_W: misalign = |sel_addr[1:0];
        default: misalign = |sel_addr[1:0];
      endcase
    end else begin
      unique case (sel_ltype)
        LOAD_B, LOAD_BU: misalign = 1'b0;
        LOAD_H, LOAD_HU: misalign = sel_addr[0];
        LOAD_W:          misalign = |sel_addr[1:0];
        default:         misalign = |sel_addr[1:0];
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every output of this block is defaulted first so no path can infer a latch.
  always_comb begin
    state_d          = state_q;
    mem_rd_en_o      = 1'b0;
    mem_wr_en_o      = 1'b0;
    mem_addr_o       = '0;
    mem_wr_data_o    = '0;
    mem_load_type_o  = '0;
    mem_store_type_o = '0;
    unique case (state_q)
      IDLE: begin
        if (accept) state_d = misalign ? ERR : ISSUE;
      end
      ISSUE: begin
        state_d          = IDLE;
        mem_rd_en_o      = ~we_q;
        mem_wr_en_o      = we_q;
        mem_addr_o       = addr_q;
        mem_wr_data_o    = wdata_q;
        mem_load_type_o  = ltype_q;
        mem_store_type_o = stype_q;
      end
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= 1'b1;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      ltype_q      <= '0;
      stype_q      <= '0;
      port_q       <= 1'b0;
    end else if (accept) begin
      last_grant_q <= sel;
      we_q         <= sel_we;
      addr_q       <= sel_addr;
      wdata_q      <= sel_wdata;
      ltype_q      <= sel_ltype;
      stype_q      <= sel_stype;
      port_q       <= sel;
    end
  end

  // Response data/err per port hold until that port's next response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_q    <= 2'b00;
      rsp_rdata_q[0] <= '0;
      rsp_rdata_q[1] <= '0;
      rsp_err_q      <= 2'b00;
    end else begin
      rsp_valid_q <= 2'b00;
      if (state_q == ISSUE) begin
        rsp_valid_q[port_q] <= 1'b1;
        rsp_rdata_q[port_q] <= we_q ? 32'h0 : mem_rd_data_i;
        rsp_err_q[port_q]   <= 1'b0;
      end else if (state_q == ERR) begin
        rsp_valid_q[port_q] <= 1'b1;
        rsp_rdata_q[port_q] <= 32'h0;
        rsp_err_q[port_q]   <= 1'b1;
      end
    end
  end

  assign p0.rsp_valid = rsp_valid_q[0];
  assign p0.rsp_rdata = rsp_rdata_q[0];
  assign p0.rsp_err   = rsp_err_q[0];
  assign p1.rsp_valid = rsp_valid_q[1];
  assign p1.rsp_rdata = rsp_rdata_q[1];
  assign p1.rsp_err   = rsp_err_q[1];

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: behavioural byte memory behind a round-robin instance,
// plus a fixed-priority instance used for the conflict pattern.
module tb_dmem_arbiter;

  localparam logic [2:0] LOAD_B  = 3'b000;
  localparam logic [2:0] LOAD_H  = 3'b001;
  localparam logic [2:0] LOAD_W  = 3'b010;
  localparam logic [2:0] LOAD_BU = 3'b100;
  localparam logic [2:0] LOAD_HU = 3'b101;
  localparam logic [1:0] STORE_B = 2'b00;
  localparam logic [1:0] STORE_H = 2'b01;
  localparam logic [1:0] STORE_W = 2'b10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.ADDR_W(8)) p0_if ();
  dmem_arbiter_if #(.ADDR_W(8)) p1_if ();
  dmem_arbiter_if #(.ADDR_W(8)) q0_if ();
  dmem_arbiter_if #(.ADDR_W(8)) q1_if ();

  logic        mem_rd_en, mem_wr_en;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wr_data, mem_rd_data;
  logic [2:0]  mem_lt;
  logic [1:0]  mem_st;

  logic        fp_rd_en, fp_wr_en;
  logic [7:0]  fp_addr;
  logic [31:0] fp_wr_data;
  logic [2:0]  fp_lt;
  logic [1:0]  fp_st;

  dmem_arbiter #(.ADDR_W(8), .FIXED_PRIO(1'b0)) dut (
    .clk(clk), .rst(rst), .p0(p0_if), .p1(p1_if),
    .mem_rd_en_o(mem_rd_en), .mem_wr_en_o(mem_wr_en), .mem_addr_o(mem_addr),
    .mem_wr_data_o(mem_wr_data), .mem_load_type_o(mem_lt), .mem_store_type_o(mem_st),
    .mem_rd_data_i(mem_rd_data)
  );

  dmem_arbiter #(.ADDR_W(8), .FIXED_PRIO(1'b1)) dut_fp (
    .clk(clk), .rst(rst), .p0(q0_if), .p1(q1_if),
    .mem_rd_en_o(fp_rd_en), .mem_wr_en_o(fp_wr_en), .mem_addr_o(fp_addr),
    .mem_wr_data_o(fp_wr_data), .mem_load_type_o(fp_lt), .mem_store_type_o(fp_st),
    .mem_rd_data_i(32'h0)
  );

  // Little-endian byte memory: async read with load-type extension, sync write.
  logic [7:0]  mem [256];
  logic [31:0] rd_word;
  always_comb begin
    rd_word = {mem[mem_addr + 8'd3], mem[mem_addr + 8'd2], mem[mem_addr + 8'd1], mem[mem_addr]};
    case (mem_lt)
      LOAD_B:  mem_rd_data = {{24{rd_word[7]}}, rd_word[7:0]};
      LOAD_BU: mem_rd_data = {24'h0, rd_word[7:0]};
      LOAD_H:  mem_rd_data = {{16{rd_word[15]}}, rd_word[15:0]};
      LOAD_HU: mem_rd_data = {16'h0, rd_word[15:0]};
      default: mem_rd_data = rd_word;
    endcase
  end

  always @(posedge clk) begin
    if (mem_wr_en) begin
      case (mem_st)
        STORE_B: mem[mem_addr] <= mem_wr_data[7:0];
        STORE_H: begin
          mem[mem_addr]        <= mem_wr_data[7:0];
          mem[mem_addr + 8'd1] <= mem_wr_data[15:8];
        end
        STORE_W: begin
          mem[mem_addr]        <= mem_wr_data[7:0];
          mem[mem_addr + 8'd1] <= mem_wr_data[15:8];
          mem[mem_addr + 8'd2] <= mem_wr_data[23:16];
          mem[mem_addr + 8'd3] <= mem_wr_data[31:24];
        end
        default: ;
      endcase
    end
  end

  int          cyc = 0;
  int          en_cnt = 0;
  logic [7:0]  last_addr = '0;
  logic [31:0] last_wdata = '0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (mem_rd_en || mem_wr_en) begin
      en_cnt     <= en_cnt + 1;
      last_addr  <= mem_addr;
      last_wdata <= mem_wr_data;
    end
  end

  logic outs_any;
  assign outs_any = |{mem_rd_en, mem_wr_en, mem_addr, mem_wr_data, mem_lt, mem_st,
                      p0_if.req_ready, p0_if.rsp_valid, p0_if.rsp_rdata, p0_if.rsp_err,
                      p1_if.req_ready, p1_if.rsp_valid, p1_if.rsp_rdata, p1_if.rsp_err};

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input int port, input logic v, input logic we, input logic [7:0] addr,
                       input logic [31:0] wd, input logic [2:0] lt, input logic [1:0] st);
    if (port == 0) begin
      p0_if.req_valid = v; p0_if.req_we = we; p0_if.req_addr = addr;
      p0_if.req_wdata = wd; p0_if.req_ltype = lt; p0_if.req_stype = st;
    end else begin
      p1_if.req_valid = v; p1_if.req_we = we; p1_if.req_addr = addr;
      p1_if.req_wdata = wd; p1_if.req_ltype = lt; p1_if.req_stype = st;
    end
  endtask

  // One access: returns response data/err, handshake-to-response latency and memory enables used.
  task automatic access(input int port, input logic we, input logic [7:0] addr,
                        input logic [31:0] wd, input logic [2:0] lt, input logic [1:0] st,
                        output logic [31:0] rd, output logic err, output int lat, output int den);
    int n;
    int hs;
    int en0;
    logic seen;
    rd = '0; err = 1'b0; lat = -1; den = -1;
    @(posedge clk); #1;
    en0 = en_cnt;
    drive(port, 1'b1, we, addr, wd, lt, st);
    n = 0;
    seen = 1'b0;
    while (!seen && n < 20) begin
      @(negedge clk);
      seen = (port == 0) ? p0_if.req_ready : p1_if.req_ready;
      n++;
    end
    hs = cyc;
    @(posedge clk); #1;
    drive(port, 1'b0, 1'b0, 8'h0, 32'h0, 3'b0, 2'b0);
    if (!seen) begin
      chk("timeout_ready", 32'(seen), 32'd1);
      return;
    end
    n = 0;
    seen = 1'b0;
    while (!seen && n < 10) begin
      @(negedge clk);
      seen = (port == 0) ? p0_if.rsp_valid : p1_if.rsp_valid;
      n++;
    end
    if (!seen) begin
      chk("timeout_rsp", 32'(seen), 32'd1);
      return;
    end
    rd  = (port == 0) ? p0_if.rsp_rdata : p1_if.rsp_rdata;
    err = (port == 0) ? p0_if.rsp_err : p1_if.rsp_err;
    lat = cyc - hs;
    den = en_cnt - en0;
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat, den, n_rsp;
  logic [1:0]  rr_exp [6] = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00};
  logic [1:0]  fp_exp [6] = '{2'b01, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00};

  initial begin
    drive(0, 1'b0, 1'b0, 8'h0, 32'h0, 3'b0, 2'b0);
    drive(1, 1'b0, 1'b0, 8'h0, 32'h0, 3'b0, 2'b0);
    {q0_if.req_valid, q0_if.req_we, q0_if.req_addr, q0_if.req_wdata, q0_if.req_ltype, q0_if.req_stype} = '0;
    {q1_if.req_valid, q1_if.req_we, q1_if.req_addr, q1_if.req_wdata, q1_if.req_ltype, q1_if.req_stype} = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", 32'(outs_any), 32'd0);
    rst = 1'b0;

    // Word store then load, checking the issued address/data and the N+2 latency.
    access(0, 1'b1, 8'h10, 32'hDEADBEEF, LOAD_W, STORE_W, rd, er, lat, den);
    chk("sw_err", 32'(er), 32'd0);
    chk("sw_rdata", rd, 32'h0);
    chk("sw_latency", lat, 32'd2);
    chk("sw_mem_addr", 32'(last_addr), 32'h10);
    chk("sw_mem_wdata", last_wdata, 32'hDEADBEEF);
    access(0, 1'b0, 8'h10, 32'h0, LOAD_W, STORE_W, rd, er, lat, den);
    chk("lw_rdata", rd, 32'hDEADBEEF);
    chk("lw_err", 32'(er), 32'd0);
    chk("lw_latency", lat, 32'd2);
    chk("lw_enables", den, 32'd1);
    repeat (3) @(negedge clk);
    chk("rsp_pulse_low", 32'(p0_if.rsp_valid), 32'd0);
    chk("rsp_rdata_hold", p0_if.rsp_rdata, 32'hDEADBEEF);

    // Byte/half stores from the loader port, sign- and zero-extended loads on port 0.
    access(1, 1'b1, 8'h21, 32'h12345680, LOAD_W, STORE_B, rd, er, lat, den);
    chk("sb_err", 32'(er), 32'd0);
    access(0, 1'b0, 8'h21, 32'h0, LOAD_B, STORE_W, rd, er, lat, den);
    chk("lb_rdata", rd, 32'hFFFFFF80);
    access(0, 1'b0, 8'h21, 32'h0, LOAD_BU, STORE_W, rd, er, lat, den);
    chk("lbu_rdata", rd, 32'h00000080);
    access(1, 1'b1, 8'h22, 32'h0000BEEF, LOAD_W, STORE_H, rd, er, lat, den);
    access(0, 1'b0, 8'h22, 32'h0, LOAD_H, STORE_W, rd, er, lat, den);
    chk("lh_rdata", rd, 32'hFFFFBEEF);
    access(1, 1'b0, 8'h22, 32'h0, LOAD_HU, STORE_W, rd, er, lat, den);
    chk("lhu_p1_rdata", rd, 32'h0000BEEF);

    // Misaligned accesses: error response, no memory traffic, memory untouched.
    access(1, 1'b1, 8'h04, 32'h11223344, LOAD_W, STORE_W, rd, er, lat, den);
    access(0, 1'b0, 8'h13, 32'h0, LOAD_W, STORE_W, rd, er, lat, den);
    chk("lw_mis_err", 32'(er), 32'd1);
    chk("lw_mis_rdata", rd, 32'h0);
    chk("lw_mis_latency", lat, 32'd2);
    chk("lw_mis_enables", den, 32'd0);
    access(0, 1'b1, 8'h05, 32'h0000AAAA, LOAD_W, STORE_H, rd, er, lat, den);
    chk("sh_mis_err", 32'(er), 32'd1);
    chk("sh_mis_enables", den, 32'd0);
    access(0, 1'b0, 8'h04, 32'h0, LOAD_W, STORE_W, rd, er, lat, den);
    chk("mem_unchanged", rd, 32'h11223344);
    access(1, 1'b0, 8'hFF, 32'h0, LOAD_HU, STORE_W, rd, er, lat, den);
    chk("lhu_top_mis_err", 32'(er), 32'd1);
    access(0, 1'b0, 8'h21, 32'h0, LOAD_H, STORE_W, rd, er, lat, den);
    chk("lh_odd_err", 32'(er), 32'd1);

    // Unknown store code: still issued as a write, no error.
    access(0, 1'b1, 8'h08, 32'h55, LOAD_W, 2'b11, rd, er, lat, den);
    chk("st_unknown_err", 32'(er), 32'd0);
    chk("st_unknown_enables", den, 32'd1);

    // Loader initialises the top word, then port 0 reads it.
    access(1, 1'b1, 8'hFC, 32'h00000034, LOAD_W, STORE_W, rd, er, lat, den);
    access(0, 1'b0, 8'hFC, 32'h0, LOAD_W, STORE_W, rd, er, lat, den);
    chk("lw_top_rdata", rd, 32'h00000034);

    // Reset asserted during an ISSUE cycle.
    @(posedge clk); #1;
    drive(0, 1'b1, 1'b0, 8'h10, 32'h0, LOAD_W, STORE_W);
    @(negedge clk);
    chk("rm_ready", 32'(p0_if.req_ready), 32'd1);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 8'h0, 32'h0, 3'b0, 2'b0);
    chk("rm_issue_rd_en", 32'(mem_rd_en), 32'd1);
    rst = 1'b1;
    #1;
    chk("rm_outputs_zero", 32'(outs_any), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    n_rsp = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (p0_if.rsp_valid || p1_if.rsp_valid) n_rsp++;
    end
    chk("rm_no_response", n_rsp, 32'd0);

    // Both ports valid for six cycles on both arbitration modes.
    @(posedge clk); #1;
    drive(0, 1'b1, 1'b0, 8'h10, 32'h0, LOAD_W, STORE_W);
    drive(1, 1'b1, 1'b0, 8'hFC, 32'h0, LOAD_W, STORE_W);
    {q0_if.req_valid, q0_if.req_ltype} = {1'b1, LOAD_W};
    {q1_if.req_valid, q1_if.req_ltype} = {1'b1, LOAD_W};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk($sformatf("rr_grant%0d", i), 32'({p1_if.req_ready, p0_if.req_ready}), 32'(rr_exp[i]));
      chk($sformatf("fp_grant%0d", i), 32'({q1_if.req_ready, q0_if.req_ready}), 32'(fp_exp[i]));
      if (i == 2) chk("rr_rsp_p0", {p0_if.rsp_valid, p0_if.rsp_rdata[30:0]}, {1'b1, 31'h5EADBEEF});
      if (i == 4) chk("rr_rsp_p1", {p1_if.rsp_valid, p1_if.rsp_rdata[30:0]}, {1'b1, 31'h00000034});
    end
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 8'h0, 32'h0, 3'b0, 2'b0);
    drive(1, 1'b0, 1'b0, 8'h0, 32'h0, 3'b0, 2'b0);
    q0_if.req_valid = 1'b0;
    q1_if.req_valid = 1'b0;
    repeat (4) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
